tile_frame_buffer: RTL and testbench
====================================

TILE_FRAME_BUFFER -- requirements
Module: tile_frame_buffer

Interface
REQ-001 SHALL have parameter COLS, default 40, tile columns per frame.
REQ-002 SHALL have parameter ROWS, default 30, tile rows per frame.
REQ-003 SHALL have parameter PIX_W, default 3, bits per tile colour.
REQ-004 SHALL have parameter RESET_FILL, default 3'b010 (PIX_W wide), colour written by the post-reset clear.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_col / wr_row  input  CW=$clog2(COLS) / RW=$clog2(ROWS)  write tile coordinate.
REQ-009 wr_data  input  PIX_W  write colour.
REQ-010 wr_ready  output  1  high when host writes are accepted.
REQ-011 rd_en  input  1  read request (display side).
REQ-012 rd_col / rd_row  input  CW / RW  read tile coordinate.
REQ-013 rd_data  output  PIX_W  registered read colour.
REQ-014 rd_valid  output  1  rd_data valid this cycle.
REQ-015 clr_start  input  1  start full-frame clear.
REQ-016 clr_data  input  PIX_W  clear colour, sampled with clr_start.
REQ-017 clr_busy  output  1  clear sweep in progress.
REQ-018 clr_done  output  1  one-cycle pulse at end of sweep.

Function
REQ-019 SHALL store COLS*ROWS entries of PIX_W bits; linear address = row*COLS + col, width $clog2(COLS*ROWS).
REQ-020 Write and read ports SHALL be independent; one write and one read per cycle.
REQ-021 Read latency SHALL be 1 cycle: rd_en at edge N -> rd_data/rd_valid at N+1; rd_valid low when rd_en was low; rd_data holds last value when rd_valid low.
REQ-022 Same-address read and write in one cycle SHALL return the old (pre-write) data.
REQ-023 Read with rd_col>=COLS or rd_row>=ROWS SHALL return rd_data=0 with rd_valid=1.
REQ-024 Write with wr_col>=COLS or wr_row>=ROWS SHALL be dropped; memory unchanged.
REQ-025 wr_ready SHALL equal ~clr_busy; host writes with wr_ready low SHALL be dropped (no queuing).
REQ-026 Clear FSM states: IDLE, SWEEP, DONE.
REQ-027 IDLE -> SWEEP on clr_start; clr_data latched, sweep address := 0, clr_busy=1 next cycle.
REQ-028 SWEEP SHALL write one entry per cycle at addresses 0..COLS*ROWS-1 ascending; after last address -> DONE.
REQ-029 DONE SHALL last exactly one cycle with clr_done=1, clr_busy=0, then -> IDLE; full sweep = COLS*ROWS cycles of clr_busy.
REQ-030 clr_start while in SWEEP or DONE SHALL be ignored.
REQ-031 Reads SHALL remain serviced during SWEEP; result per REQ-022 with sweep as the writer.
REQ-032 Sweep address counter SHALL not wrap; terminal compare is exact on COLS*ROWS-1, valid for non-power-of-two depths.

Reset
REQ-033 While rst_n=0 at a clock edge: rd_data=0, rd_valid=0, clr_done=0, FSM forced to SWEEP at address 0 with latched colour RESET_FILL, clr_busy=1, wr_ready=0.
REQ-034 After rst_n release the sweep SHALL run to completion per REQ-028/029; memory SHALL not be cleared by reset in one cycle.
REQ-035 Reset asserted mid-sweep SHALL restart the sweep from address 0 with RESET_FILL.

Configuration
REQ-036 Macro TILE_FB_CHECKER_EN: when defined, sweep SHALL write latched colour to tiles where (row+col) is even and its bitwise inverse where odd; when undefined, all tiles get the latched colour.
REQ-037 Sweep SHALL track row/col counters (no divider) so the checker parity needs no address division.

Verification
REQ-038 Reset 2 cycles, release -> clr_busy high exactly 1200 cycles, clr_done pulse once, then read (0,0)=3'b010 and (39,29)=3'b010 (macro off).
REQ-039 Macro on, same reset -> read (0,0)=3'b010, (1,0)=3'b101, (1,1)=3'b010.
REQ-040 After clear: write (5,7)=3'b110, next cycle read (5,7) -> rd_valid=1, rd_data=3'b110 one cycle after rd_en; simultaneous read/write of (5,7) with 3'b001 returns 3'b110.
REQ-041 clr_start with clr_data=3'b111, host write (2,2)=3'b000 during sweep -> wr_ready=0, write dropped, (2,2) reads 3'b111 after clr_done.
REQ-042 Write (40,0)=3'b100 and read (0,30) -> memory unchanged, rd_data=0, rd_valid=1.
REQ-043 Assert rst_n=0 at sweep address 600 of a 3'b111 clear -> sweep restarts at 0, full 1200 cycles, all tiles 3'b010.

Source files
------------

// File: rtl/tile_frame_buffer.sv
// Tile-colour frame buffer: registered dual-port reads, host writes, and a full-frame clear sweep.
// Optional build macro TILE_FB_CHECKER_EN makes the sweep paint a checkerboard of colour / ~colour.
module tile_frame_buffer #(
    parameter int               COLS       = 40,
    parameter int               ROWS       = 30,
    parameter int               PIX_W      = 3,
    parameter logic [PIX_W-1:0] RESET_FILL = 3'b010,
    localparam int              CW         = $clog2(COLS),
    localparam int              RW         = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_col,
    input  logic [RW-1:0]    wr_row,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    input  logic [CW-1:0]    rd_col,
    input  logic [RW-1:0]    rd_row,
    output logic [PIX_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clr_start,
    input  logic [PIX_W-1:0] clr_data,
    output logic             clr_busy,
    output logic             clr_done
);

    localparam int             DEPTH     = COLS * ROWS;
    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [CW-1:0]  LAST_COL  = CW'(COLS - 1);
    // One extra bit so a power-of-two COLS/ROWS does not truncate to zero.
    localparam logic [CW:0]    COLS_W    = (CW + 1)'(COLS);
    localparam logic [RW:0]    ROWS_W    = (RW + 1)'(ROWS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    sw_addr_q, sw_addr_d;
    logic [CW-1:0]    sw_col_q, sw_col_d;
    logic [RW-1:0]    sw_row_q, sw_row_d;
    logic [PIX_W-1:0] clr_colour_q, clr_colour_d;
    logic [PIX_W-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic [PIX_W-1:0] mem_q [DEPTH];

    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [PIX_W-1:0] mem_wdata;
    logic [PIX_W-1:0] sweep_pix;
    logic             wr_in_range;
    logic             rd_in_range;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;

    always_comb begin
        wr_in_range = ({1'b0, wr_col} < COLS_W) && ({1'b0, wr_row} < ROWS_W);
        rd_in_range = ({1'b0, rd_col} < COLS_W) && ({1'b0, rd_row} < ROWS_W);
        wr_addr     = AW'(wr_row) * AW'(COLS) + AW'(wr_col);
        rd_addr     = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
    end

`ifdef TILE_FB_CHECKER_EN
    always_comb begin
        sweep_pix = (sw_col_q[0] ^ sw_row_q[0]) ? ~clr_colour_q : clr_colour_q;
    end
`else
    always_comb begin
        sweep_pix = clr_colour_q;
    end
`endif

    always_comb begin
        state_d      = state_q;
        sw_addr_d    = sw_addr_q;
        sw_col_d     = sw_col_q;
        sw_row_d     = sw_row_q;
        clr_colour_d = clr_colour_q;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;

        // Host writes share the single write port outside SWEEP only.
        if (state_q != SWEEP && wr_en && wr_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = wr_addr;
            mem_wdata = wr_data;
        end

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d      = SWEEP;
                    sw_addr_d    = '0;
                    sw_col_d     = '0;
                    sw_row_d     = '0;
                    clr_colour_d = clr_data;
                end
            end
            SWEEP: begin
                mem_we    = 1'b1;
                mem_waddr = sw_addr_q;
                mem_wdata = sweep_pix;
                if (sw_addr_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    sw_addr_d = sw_addr_q + 1'b1;
                    if (sw_col_q == LAST_COL) begin
                        sw_col_d = '0;
                        sw_row_d = sw_row_q + 1'b1;
                    end else begin
                        sw_col_d = sw_col_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_in_range ? mem_q[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SWEEP;
            sw_addr_q    <= '0;
            sw_col_q     <= '0;
            sw_row_q     <= '0;
            clr_colour_q <= RESET_FILL;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sw_addr_q    <= sw_addr_d;
            sw_col_q     <= sw_col_d;
            sw_row_q     <= sw_row_d;
            clr_colour_q <= clr_colour_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Storage is deliberately not reset; the sweep that follows reset repaints it.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_data  = rd_data_q;
        rd_valid = rd_valid_q;
        clr_busy = (state_q == SWEEP);
        clr_done = (state_q == DONE);
        wr_ready = (state_q != SWEEP);
    end

endmodule

// File: tb/tb_tile_frame_buffer.sv
// Self-checking bench for tile_frame_buffer: reference memory model plus an expected-read queue.
module tb_tile_frame_buffer;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int PIX_W = 3;
    localparam int CW    = 6;
    localparam int RW    = 5;
    localparam int DEPTH = COLS * ROWS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [CW-1:0]    wr_col;
    logic [RW-1:0]    wr_row;
    logic [PIX_W-1:0] wr_data;
    logic             wr_ready;
    logic             rd_en;
    logic [CW-1:0]    rd_col;
    logic [RW-1:0]    rd_row;
    logic [PIX_W-1:0] rd_data;
    logic             rd_valid;
    logic             clr_start;
    logic [PIX_W-1:0] clr_data;
    logic             clr_busy;
    logic             clr_done;

    int vectors = 0;
    int errors  = 0;

    logic [PIX_W-1:0] model [DEPTH];
    logic [PIX_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    tile_frame_buffer #(
        .COLS(COLS),
        .ROWS(ROWS),
        .PIX_W(PIX_W),
        .RESET_FILL(3'b010)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_col(wr_col),
        .wr_row(wr_row),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .rd_en(rd_en),
        .rd_col(rd_col),
        .rd_row(rd_row),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .clr_start(clr_start),
        .clr_data(clr_data),
        .clr_busy(clr_busy),
        .clr_done(clr_done)
    );

    function automatic logic [PIX_W-1:0] fill_val(input int c, input int r, input logic [PIX_W-1:0] colour);
`ifdef TILE_FB_CHECKER_EN
        return ((c + r) % 2 == 1) ? ~colour : colour;
`else
        return colour;
`endif
    endfunction

    task automatic model_fill(input logic [PIX_W-1:0] colour);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                model[r * COLS + c] = fill_val(c, r, colour);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input int c, input int r);
        rd_en  = 1'b1;
        rd_col = CW'(c);
        rd_row = RW'(r);
        if (c < COLS && r < ROWS) exp_q.push_back(model[r * COLS + c]);
        else                      exp_q.push_back('0);
    endtask

    // Runs from the current sample point until the DONE pulse (bounded), then a short tail.
    task automatic run_until_done(output int busy, output int dones);
        busy  = 0;
        dones = 0;
        for (int i = 0; i < 5000; i++) begin
            if (clr_busy) busy++;
            if (clr_done) begin
                dones++;
                break;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clr_done) dones++;
        end
    endtask

    task automatic test_reset();
        int busy, dones;
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== '0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_valid=%b rd_data=%b clr_done=%b, expected 0 000 0", rd_valid, rd_data, clr_done);
        end
        vectors++;
        if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got clr_busy=%b wr_ready=%b, expected 1 0", clr_busy, wr_ready);
        end
        rst_n = 1'b1;
        run_until_done(busy, dones);
        model_fill(3'b010);
        vectors++;
        if (busy !== 1200) begin
            errors++;
            $display("FAIL reset_sweep_len: got %0d busy cycles, expected 1200", busy);
        end
        vectors++;
        if (dones !== 1) begin
            errors++;
            $display("FAIL reset_done_pulse: got %0d pulses, expected 1", dones);
        end
        begin
            int cs[4] = '{0, 39, 1, 1};
            int rs[4] = '{0, 29, 0, 1};
            for (int i = 0; i < 4; i++) begin
                logic [PIX_W-1:0] e;
                issue_read(cs[i], rs[i]);
                tick();
                rd_en = 1'b0;
                e = exp_q.pop_front();
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== e) begin
                    errors++;
                    $display("FAIL reset_fill(%0d,%0d): got valid=%b data=%b, expected valid=1 data=%b", cs[i], rs[i], rd_valid, rd_data, e);
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic [PIX_W-1:0] e;
        wr_en = 1'b1; wr_col = 6'd5; wr_row = 5'd7; wr_data = 3'b110;
        model[7 * COLS + 5] = 3'b110;
        tick();
        wr_en = 1'b0;
        issue_read(5, 7);
        tick();
        rd_en = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL write_then_read: got valid=%b data=%b, expected valid=1 data=%b", rd_valid, rd_data, e);
        end
        wr_en = 1'b1; wr_data = 3'b001;
        issue_read(5, 7);
        model[7 * COLS + 5] = 3'b001;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL same_addr_old_data: got valid=%b data=%b, expected valid=1 data=%b", rd_valid, rd_data, e);
        end
        issue_read(5, 7);
        tick();
        rd_en = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL after_collision: got valid=%b data=%b, expected valid=1 data=%b", rd_valid, rd_data, e);
        end
    endtask

    task automatic test_out_of_range();
        int cs[3] = '{0, 0, 40};
        int rs[3] = '{30, 1, 0};
        wr_en = 1'b1; wr_col = 6'd40; wr_row = 5'd0; wr_data = 3'b100;
        for (int i = 0; i < 3; i++) begin
            logic [PIX_W-1:0] e;
            issue_read(cs[i], rs[i]);
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            e = exp_q.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("FAIL out_of_range(%0d,%0d): got valid=%b data=%b, expected valid=1 data=%b", cs[i], rs[i], rd_valid, rd_data, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PIX_W-1:0] e;
        logic [PIX_W-1:0] last;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_col = CW'(i); wr_row = 5'd3; wr_data = PIX_W'(i);
            issue_read(i, 3);
            model[3 * COLS + i] = PIX_W'(i);
            tick();
            e = exp_q.pop_front();
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("FAIL b2b_rmw(%0d,3): got valid=%b data=%b, expected valid=1 data=%b", i, rd_valid, rd_data, e);
            end
        end
        wr_en = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            issue_read(i, 3);
            tick();
            e = exp_q.pop_front();
            last = e;
            vectors++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                errors++;
                $display("FAIL b2b_read(%0d,3): got valid=%b data=%b, expected valid=1 data=%b", i, rd_valid, rd_data, e);
            end
        end
        rd_en = 1'b0;
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== last) begin
            errors++;
            $display("FAIL idle_hold: got valid=%b data=%b, expected valid=0 data=%b", rd_valid, rd_data, last);
        end
    endtask

    task automatic test_clear_blocks_write();
        int busy, dones, pre;
        logic [PIX_W-1:0] e;
        clr_data = 3'b111; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        pre = 0;
        for (int i = 0; i < 100; i++) begin
            if (clr_busy) pre++;
            tick();
        end
        vectors++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_ready_in_sweep: got %b, expected 0", wr_ready);
        end
        // Host write to an already-swept tile, a restart attempt, and a read of the tile being swept now.
        wr_en = 1'b1; wr_col = 6'd2; wr_row = 5'd2; wr_data = 3'b000;
        clr_start = 1'b1; clr_data = 3'b000;
        issue_read(20, 2);
        tick();
        wr_en = 1'b0; clr_start = 1'b0; rd_en = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL sweep_collision: got valid=%b data=%b, expected valid=1 data=%b", rd_valid, rd_data, e);
        end
        run_until_done(busy, dones);
        busy = busy + pre + 1;
        model_fill(3'b111);
        vectors++;
        if (busy !== 1200 || dones !== 1) begin
            errors++;
            $display("FAIL clear_len: got busy=%0d pulses=%0d, expected busy=1200 pulses=1", busy, dones);
        end
        issue_read(2, 2);
        tick();
        rd_en = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
            errors++;
            $display("FAIL dropped_write: got valid=%b data=%b, expected valid=1 data=%b", rd_valid, rd_data, e);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int busy, dones;
        logic [PIX_W-1:0] e;
        clr_data = 3'b111; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 600; i++) tick();
        issue_read(2, 2);
        tick();
        rd_en = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== fill_val(2, 2, 3'b111) || rd_data !== e) begin
            errors++;
            $display("FAIL read_during_sweep: got valid=%b data=%b, expected valid=1 data=%b", rd_valid, rd_data, fill_val(2, 2, 3'b111));
        end
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== '0 || clr_busy !== 1'b1 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_reset: got valid=%b data=%b busy=%b done=%b, expected 0 000 1 0", rd_valid, rd_data, clr_busy, clr_done);
        end
        rst_n = 1'b1;
        run_until_done(busy, dones);
        model_fill(3'b010);
        vectors++;
        if (busy !== 1200 || dones !== 1) begin
            errors++;
            $display("FAIL restart_len: got busy=%0d pulses=%0d, expected busy=1200 pulses=1", busy, dones);
        end
        begin
            int cs[5] = '{0, 39, 0, 39, 2};
            int rs[5] = '{0, 14, 15, 29, 2};
            for (int i = 0; i < 5; i++) begin
                issue_read(cs[i], rs[i]);
                tick();
                e = exp_q.pop_front();
                vectors++;
                if (rd_valid !== 1'b1 || rd_data !== e) begin
                    errors++;
                    $display("FAIL restart_fill(%0d,%0d): got valid=%b data=%b, expected valid=1 data=%b", cs[i], rs[i], rd_valid, rd_data, e);
                end
            end
            rd_en = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0;
        rd_en = 1'b0; rd_col = '0; rd_row = '0; clr_start = 1'b0; clr_data = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_clear_blocks_write();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
